// File: rtl/sparc_dp_pkg.sv
// Shared SPARC datapath definitions: word width, channel count and the
// channel-select type used by the write-back distribution logic.
package sparc_dp_pkg;

    localparam int DP_WIDTH = 32;
    localparam int CH_SEL_W = 2;
    localparam int NUM_CH   = 4;

    typedef logic [CH_SEL_W-1:0] ch_sel_t;

endpackage

// File: rtl/demux_chan_fifo.sv
// One show-ahead channel FIFO: head word is presented on dout whenever the
// channel holds data, and dout reads 0 while the channel is empty.
module demux_chan_fifo
    import sparc_dp_pkg::*;
#(
    parameter  int WIDTH = DP_WIDTH,
    parameter  int DEPTH = 2,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;

    // The caller never pushes when full or pops when empty, so the count
    // only ever needs the plain +1/-1 cases. Pointers wrap naturally
    // because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (push) begin
                r_mem[r_wr_ptr] <= din;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign dout  = (r_count != '0) ? r_mem[r_rd_ptr] : '0;
    assign count = r_count;

endmodule

// File: rtl/demux1to4_buf.sv
// 1:4 write-back distribution demux: steers one datapath word into one of
// four independently drained channel FIFOs selected by in_sel.
module demux1to4_buf
    import sparc_dp_pkg::*;
#(
    parameter  int WIDTH = DP_WIDTH,
    parameter  int DEPTH = 2,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  ch_sel_t          in_sel,
    input  logic [WIDTH-1:0] in_data,
    output logic [3:0]       out_valid,
    input  logic [3:0]       out_ready,
    output logic [WIDTH-1:0] out_data_0,
    output logic [WIDTH-1:0] out_data_1,
    output logic [WIDTH-1:0] out_data_2,
    output logic [WIDTH-1:0] out_data_3,
    output logic [3:0]       ch_full,
    output logic [3:0]       ch_empty
);

    // Handshake: a word moves when valid & ready are both high at a rising
    // edge; a producer seeing valid & ~ready holds sel/data stable, and
    // ready never depends on the consumer side of the same cycle.
    logic [WIDTH-1:0] w_dout  [NUM_CH];
    logic [AW:0]      w_count [NUM_CH];
    logic [3:0]       w_push;
    logic [3:0]       w_pop;

    assign in_ready = ~ch_full[in_sel];

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        assign w_push[k]    = in_valid & in_ready & (in_sel == ch_sel_t'(k));
        assign w_pop[k]     = out_valid[k] & out_ready[k];
        assign out_valid[k] = (w_count[k] != '0);
        assign ch_full[k]   = (w_count[k] == (AW+1)'(DEPTH));
        assign ch_empty[k]  = (w_count[k] == '0);

        demux_chan_fifo #(
            .WIDTH (WIDTH),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk     (clk),
            .reset_n (reset_n),
            .push    (w_push[k]),
            .pop     (w_pop[k]),
            .din     (in_data),
            .dout    (w_dout[k]),
            .count   (w_count[k])
        );
    end

    assign out_data_0 = w_dout[0];
    assign out_data_1 = w_dout[1];
    assign out_data_2 = w_dout[2];
    assign out_data_3 = w_dout[3];

endmodule
